// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift, iterative shift-add multiply, restoring divu/remu (SEQ_ALU_DIV_EN).
// Latency 1 cycle (single) / WIDTH+1 (mul, div); accepts only in IDLE, result held in DONE until out_ready.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SAW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [SAW-1:0]   sa,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_CLR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_LUI  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  localparam logic [SAW-1:0] ITER_LAST = SAW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_nxt;
  logic               accept, is_mul, div_iter;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic [SAW-1:0]     cnt;
  logic [WIDTH-1:0]   single_res, sum_ab, diff_ab;
  logic               single_ovf, single_dz;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign accept = in_valid & in_ready;
  assign is_mul = (op == OP_MUL);

`ifdef SEQ_ALU_DIV_EN
  logic               op_rem;
  logic [WIDTH:0]     div_rs;
  logic               div_ok;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;

  // A zero divisor is resolved in one cycle, so only nonzero divisors iterate.
  assign div_iter = ((op == OP_DIVU) || (op == OP_REMU)) && (num2 != '0);

  // {acc_hi, acc_lo} = {partial remainder, dividend shifting in / quotient shifting out}.
  always_comb begin
    div_rs   = {acc_hi, acc_lo[WIDTH-1]};
    div_ok   = (div_rs >= {1'b0, opnd});
    div_sub  = div_rs[WIDTH-1:0] - opnd;
    div_next = {(div_ok ? div_sub : div_rs[WIDTH-1:0]), acc_lo[WIDTH-2:0], div_ok};
  end
`else
  assign div_iter = 1'b0;
`endif

  // {acc_hi, acc_lo} = {partial product, remaining multiplier bits}; shift right each step.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc_lo[WIDTH-1:1]};
  end

  always_comb begin
    single_res = '0;
    single_ovf = 1'b0;
    single_dz  = 1'b0;
    sum_ab     = num1 + num2;
    diff_ab    = num1 - num2;
    case (op)
      OP_AND:  single_res = num1 & num2;
      OP_OR:   single_res = num1 | num2;
      OP_ADD: begin
        single_res = sum_ab;
        single_ovf = (num1[WIDTH-1] == num2[WIDTH-1]) && (sum_ab[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_NOT:  single_res = ~num1;
      OP_CLR:  single_res = '0;
      OP_SUB: begin
        single_res = diff_ab;
        single_ovf = (num1[WIDTH-1] != num2[WIDTH-1]) && (diff_ab[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
      OP_XOR:  single_res = num1 ^ num2;
      OP_LUI:  single_res = {num2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  single_res = num2 << sa;
      OP_SRL:  single_res = num2 >> sa;
      OP_SRA:  single_res = $signed(num2) >>> sa;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (num1 < num2)};
      OP_DIVU, OP_REMU: begin
`ifdef SEQ_ALU_DIV_EN
        single_res = (op == OP_DIVU) ? {WIDTH{1'b1}} : num1;
        single_dz  = 1'b1;
`else
        single_ovf = 1'b1;
`endif
      end
      default: single_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) state_nxt = MUL;
`ifdef SEQ_ALU_DIV_EN
          else if (div_iter) state_nxt = DIV;
`endif
          else state_nxt = DONE;
        end
      end
      MUL:  if (cnt == '0) state_nxt = DONE;
`ifdef SEQ_ALU_DIV_EN
      DIV:  if (cnt == '0) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      op_rem   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opnd   <= is_mul ? num1 : num2;
            acc_hi <= '0;
            acc_lo <= is_mul ? num2 : num1;
            cnt    <= ITER_LAST;
`ifdef SEQ_ALU_DIV_EN
            op_rem <= (op == OP_REMU);
`endif
            if (!is_mul && !div_iter) begin
              result   <= single_res;
              zero     <= (single_res == '0);
              overflow <= single_ovf;
              div_zero <= single_dz;
            end
          end
        end
        MUL: begin
          {acc_hi, acc_lo} <= mul_next;
          cnt              <= cnt - SAW'(1);
          if (cnt == '0) begin
            result   <= mul_next[WIDTH-1:0];
            zero     <= (mul_next[WIDTH-1:0] == '0);
            overflow <= |mul_next[2*WIDTH-1:WIDTH];
            div_zero <= 1'b0;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          {acc_hi, acc_lo} <= div_next;
          cnt              <= cnt - SAW'(1);
          if (cnt == '0) begin
            result   <= op_rem ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
            zero     <= ((op_rem ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0]) == '0);
            overflow <= 1'b0;
            div_zero <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU. Operand width is set by WIDTH.
- Single-cycle logic, arithmetic and shift ops complete in one cycle.
- Multiply (shift-add) and unsigned divide/remainder (restoring) run iteratively.
- Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on in_ready/out_valid instead of carrying a combinational multiplier.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- SAW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept a new op.
- num1  in  WIDTH  operand A.
- num2  in  WIDTH  operand B / sign-extended immediate.
- sa  in  SAW  shift amount.
- op  in  4  operation code.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (add/sub) or high half nonzero (mul).
- div_zero  out  1  divide/remainder with num2 == 0.

Behaviour:
- Reset (rst_n low, async): state IDLE; result=0, zero=0, overflow=0, div_zero=0, out_valid=0. in_ready=1 after reset releases. Reset mid-operation aborts the op with no output.
- Accept: in_valid & in_ready on a rising edge latches num1/num2/sa/op. in_ready=1 only in IDLE.
- Op codes:
  - 0000 and; 0001 or; 0010 add; 0011 mul (low WIDTH bits, unsigned); 0100 not num1; 0101 clr.
  - 0110 sub; 0111 slt (signed); 1000 xor; 1001 lui = {num2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 1010 sll num2 by sa; 1011 srl num2 by sa; 1100 sra num2 by sa; 1101 sltu.
  - 1110 divu quotient; 1111 remu remainder.
- States:
  - IDLE: accept an op. Single-cycle op -> computes and goes to DONE. 0011 -> MUL. 1110/1111 -> DIV.
  - MUL: WIDTH iterations, one multiplier bit per cycle, 2*WIDTH accumulator; then DONE.
  - DIV: WIDTH iterations of restoring subtract, one quotient bit per cycle; then DONE.
  - DONE: out_valid=1 and result/flags held stable until out_ready=1. Then -> IDLE, out_valid=0.
- Latency, accept edge to out_valid high:
  - single-cycle ops: 1 cycle.
  - mul, div/rem: WIDTH+1 cycles.
- Throughput: no new op is accepted in the out_ready cycle. Next accept is earliest in the following cycle, so at most one op per 2 cycles.
- Arithmetic/width rules:
  - add/sub wrap modulo 2^WIDTH.
  - overflow = signed overflow for add/sub. For mul, overflow = upper WIDTH bits of the product nonzero. overflow=0 for all other ops.
  - slt/sltu result is 1 or 0, zero-extended.
  - sa >= WIDTH is impossible by width. sa=0 passes num2 unchanged.
- Divide by zero: completes in 1 cycle (no DIV state). Quotient = all ones; remainder = num1; div_zero=1. div_zero=0 for all other ops and nonzero divisors.
- zero: registered with result; valid only while out_valid=1.
- in_valid while busy: ignored; the producer holds its inputs.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: divu/remu are implemented as above, with the DIV state and divider datapath.
- Undefined: DIV state and divider logic are removed. Ops 1110/1111 complete in 1 cycle with result=0 and div_zero=0; overflow=1 flags the unsupported op.

Test Plan (WIDTH=32):
- Reset: assert rst_n=0 mid-MUL -> out_valid=0, result=0, in_ready=1 one cycle after release; no stale result appears.
- add: 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, out_valid 1 cycle after accept; hold out_ready=0 for 3 cycles -> values stable.
- mul: 0x00010000 * 0x00010000 -> result 0x00000000, zero=1, overflow=1. 7 * 6 -> 42 after exactly 33 cycles.
- divu/remu: 100 / 7 -> quotient 14, remainder 2, each after 33 cycles. 5 / 0 -> quotient 0xFFFFFFFF, div_zero=1, 1-cycle latency.
- shifts: sra num2=0x80000000, sa=4 -> 0xF8000000. srl same -> 0x08000000. lui num2=0x0000ABCD -> 0xABCD0000.
- Handshake: back-to-back in_valid with out_ready tied 1 -> one result every 2 cycles for single-cycle ops; in_valid during MUL is ignored (in_ready=0).
